tdm_demux4: RTL

- Four-channel time-division demultiplexer: the receive end of a 4:1 round-robin mux link.
- Accepts one WIDTH-bit word per valid beat, carried in slots 0..3, with frame_sync marking slot 0.
- Steers each word into its channel staging register and publishes all four channels together once a frame is complete.
- Sits downstream of the 4:1 selector datapath, feeding per-channel consumers.

---
 rtl/tdm_demux4_if.sv | 34 +++
 rtl/tdm_demux4.sv | 129 ++++++++++++
 2 files changed

// File: rtl/tdm_demux4_if.sv
// =============================================================================
// Module   : tdm_demux4_if
// Brief    : Stream-in / channel-out bundle for the 4-slot TDM demultiplexer.
// Revision : 1.0
// =============================================================================
`default_nettype none

interface tdm_demux4_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] din;
   logic             in_valid;
   logic             frame_sync;
   logic [WIDTH-1:0] y0;
   logic [WIDTH-1:0] y1;
   logic [WIDTH-1:0] y2;
   logic [WIDTH-1:0] y3;
   logic [3:0]       ch_strobe;
   logic             frame_done;
   logic             locked;
   logic             sync_err;

   modport master (
      output din, in_valid, frame_sync,
      input  y0, y1, y2, y3, ch_strobe, frame_done, locked, sync_err
   );

   modport slave (
      input  din, in_valid, frame_sync,
      output y0, y1, y2, y3, ch_strobe, frame_done, locked, sync_err
   );
endinterface

`default_nettype wire

// File: rtl/tdm_demux4.sv
// =============================================================================
// Module   : tdm_demux4
// Brief    : Receive end of a 4:1 round-robin TDM link; stages slots, publishes frames.
// Revision : 1.0
// =============================================================================
`default_nettype none

module tdm_demux4 #(
   parameter int WIDTH = 1
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   tdm_demux4_if.slave   bus
);

   typedef enum logic [0:0] {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_slot;
   logic [1:0]       w_slot_nxt;
   logic [1:0]       w_eff_slot;
   logic             w_accept;
   logic [3:0]       w_strobe_nxt;
   logic             w_done_nxt;
   logic             w_err_nxt;

   logic [WIDTH-1:0] r_shadow0;
   logic [WIDTH-1:0] r_shadow1;
   logic [WIDTH-1:0] r_shadow2;
   logic [WIDTH-1:0] r_y0;
   logic [WIDTH-1:0] r_y1;
   logic [WIDTH-1:0] r_y2;
   logic [WIDTH-1:0] r_y3;
   logic [3:0]       r_strobe;
   logic             r_done;
   logic             r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_HUNT;
         r_slot  <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_slot  <= w_slot_nxt;
      end
   end

   // A sync beat always forces slot 0, which also covers resync mid-frame.
   always_comb begin
      w_state_nxt  = r_state;
      w_slot_nxt   = r_slot;
      w_eff_slot   = r_slot;
      w_accept     = 1'b0;
      w_strobe_nxt = 4'b0000;
      w_done_nxt   = 1'b0;
      w_err_nxt    = 1'b0;
      case (r_state)
         ST_HUNT: begin
            if (bus.in_valid && bus.frame_sync) begin
               w_accept    = 1'b1;
               w_eff_slot  = 2'd0;
               w_state_nxt = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (bus.in_valid) begin
               w_accept   = 1'b1;
               w_eff_slot = bus.frame_sync ? 2'd0 : r_slot;
               w_err_nxt  = bus.frame_sync && (r_slot != 2'd0);
            end
         end
         default: w_state_nxt = ST_HUNT;
      endcase
      if (w_accept) begin
         w_slot_nxt   = w_eff_slot + 2'd1;
         w_strobe_nxt = 4'b0001 << w_eff_slot;
         w_done_nxt   = (w_eff_slot == 2'd3);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow0 <= '0;
         r_shadow1 <= '0;
         r_shadow2 <= '0;
         r_y0      <= '0;
         r_y1      <= '0;
         r_y2      <= '0;
         r_y3      <= '0;
         r_strobe  <= 4'b0000;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_strobe <= w_strobe_nxt;
         r_done   <= w_done_nxt;
         r_err    <= w_err_nxt;
         if (w_accept) begin
            case (w_eff_slot)
               2'd0:    r_shadow0 <= bus.din;
               2'd1:    r_shadow1 <= bus.din;
               2'd2:    r_shadow2 <= bus.din;
               default: begin
                  // Slot 3 goes straight to the output so the frame lands atomically.
                  r_y0 <= r_shadow0;
                  r_y1 <= r_shadow1;
                  r_y2 <= r_shadow2;
                  r_y3 <= bus.din;
               end
            endcase
         end
      end
   end

   assign bus.y0         = r_y0;
   assign bus.y1         = r_y1;
   assign bus.y2         = r_y2;
   assign bus.y3         = r_y3;
   assign bus.ch_strobe  = r_strobe;
   assign bus.frame_done = r_done;
   assign bus.sync_err   = r_err;
   assign bus.locked     = (r_state == ST_LOCKED);

endmodule

`default_nettype wire
